// File: rtl/pss_ram_writer.sv
// pss_ram_writer: run-time loader for the ping-pong PSS reference table.
// A framed write stream fills the inactive bank; a complete, correctly framed
// sequence swaps the read bank atomically. The read port behaves like the
// static table it replaces: registered data, one cycle of latency.
module pss_ram_writer #(
    parameter int pDAT_W   = 72,
    parameter int pDAT_Num = 2048,
    parameter int pADDR_W  = 11
) (
    input  logic              iclk,
    input  logic              irst_n,
    input  logic              iwr_sop,
    input  logic              iwr_eop,
    input  logic              iwr_val,
    input  logic [pDAT_W-1:0] iwr_dat,
    output logic              owr_rdy,
    output logic              oload_done,
    output logic              oload_err,
    output logic              obank,
    output logic              otbl_vld,
    input  logic [pADDR_W-1:0] addr,
    input  logic              ival,
    output logic [pDAT_W-1:0] odat,
    output logic              oval
);

    // Each bank spans the full address space so {bank, addr} never leaves the array.
    localparam int DEPTH = 2 ** (pADDR_W + 1);
    localparam logic [pADDR_W-1:0] LAST = pADDR_W'(pDAT_Num - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SWAP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [pADDR_W-1:0]   wcnt_q, wcnt_d;
    logic                 bank_q;
    logic                 vld_q;
    logic                 done_q;
    logic                 err_q, err_d;
    logic [pDAT_W-1:0]    odat_q;
    logic                 oval_q;

    logic                 accept;
    logic                 wr_en;
    logic [pADDR_W-1:0]   wr_lo;
    logic                 swap_go;
    logic                 wcnt_last;

    logic [pDAT_W-1:0]    mem [DEPTH];

    // State register plus write counter.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next-state logic: framing checks, write strobe and error detection.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        wr_en     = 1'b0;
        wr_lo     = wcnt_q;
        err_d     = 1'b0;
        accept    = iwr_val & owr_rdy;
        wcnt_last = (wcnt_q == LAST);
        case (state_q)
            IDLE: begin
                // Beats without sop are dropped silently while idle.
                if (accept && iwr_sop) begin
                    wr_en   = 1'b1;
                    wr_lo   = '0;
                    wcnt_d  = pADDR_W'(1);
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (iwr_sop) begin
                        // A new sop restarts the frame even if eop is also set.
                        wr_lo  = '0;
                        wcnt_d = pADDR_W'(1);
                        err_d  = 1'b1;
                    end else if (iwr_eop) begin
                        wcnt_d = '0;
                        if (wcnt_last) begin
                            state_d = SWAP;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (wcnt_last) begin
                        wcnt_d  = '0;
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        wcnt_d = wcnt_q + pADDR_W'(1);
                    end
                end
            end
            SWAP: begin
                wcnt_d  = '0;
                state_d = IDLE;
            end
            default: begin
                wcnt_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        owr_rdy = (state_q != SWAP);
        swap_go = (state_q == SWAP);
    end

    // Bank select, table-valid flag and the one-cycle status pulses.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            bank_q <= 1'b0;
            vld_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= swap_go;
            err_q  <= err_d;
            if (swap_go) begin
                bank_q <= ~bank_q;
                vld_q  <= 1'b1;
            end
        end
    end

    // Write port: always the bank not being served, so reads never collide.
    always_ff @(posedge iclk) begin
        if (wr_en) begin
            mem[{~bank_q, wr_lo}] <= iwr_dat;
        end
    end

    // Read port: registered data held while ival is low.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            odat_q <= '0;
            oval_q <= 1'b0;
        end else begin
            oval_q <= ival;
            if (ival) begin
                odat_q <= mem[{bank_q, addr}];
            end
        end
    end

    assign oload_done = done_q;
    assign oload_err  = err_q;
    assign obank      = bank_q;
    assign otbl_vld   = vld_q;
    assign odat       = odat_q;
    assign oval       = oval_q;

endmodule

// File: tb/tb_pss_ram_writer.sv
// Bench for pss_ram_writer: table of load scenarios plus hand-written
// sequences for reset, swap timing and reset during a load.
module tb_pss_ram_writer;

    localparam int DW = 72;
    localparam int N  = 2048;
    localparam int AW = 11;

    logic          iclk = 1'b0;
    logic          irst_n = 1'b0;
    logic          iwr_sop = 1'b0;
    logic          iwr_eop = 1'b0;
    logic          iwr_val = 1'b0;
    logic [DW-1:0] iwr_dat = '0;
    logic          owr_rdy;
    logic          oload_done;
    logic          oload_err;
    logic          obank;
    logic          otbl_vld;
    logic [AW-1:0] addr = '0;
    logic          ival = 1'b0;
    logic [DW-1:0] odat;
    logic          oval;

    pss_ram_writer #(.pDAT_W(DW), .pDAT_Num(N), .pADDR_W(AW)) dut (
        .iclk(iclk), .irst_n(irst_n),
        .iwr_sop(iwr_sop), .iwr_eop(iwr_eop), .iwr_val(iwr_val), .iwr_dat(iwr_dat),
        .owr_rdy(owr_rdy), .oload_done(oload_done), .oload_err(oload_err),
        .obank(obank), .otbl_vld(otbl_vld),
        .addr(addr), .ival(ival), .odat(odat), .oval(oval)
    );

    always #5 iclk = ~iclk;

    int total = 0;
    int bad   = 0;

    int done_cnt = 0;
    int err_cnt  = 0;
    int rdy_low  = 0;
    int cap_arm  = 0;
    logic [DW-1:0] dat_done = '0;
    logic [DW-1:0] dat_after = '0;

    // Pulse counters and swap-boundary capture, sampled mid-cycle.
    always @(negedge iclk) begin
        if (oload_done) done_cnt++;
        if (oload_err)  err_cnt++;
        if (!owr_rdy)   rdy_low++;
        if (cap_arm == 1 && oload_done) begin
            dat_done = odat;
            cap_arm  = 2;
        end else if (cap_arm == 2) begin
            dat_after = odat;
            cap_arm   = 3;
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One write beat, issued at a falling edge; holds until owr_rdy is seen.
    task automatic beat(input logic s, input logic e, input logic [DW-1:0] d);
        int t;
        t = 0;
        iwr_val = 1'b1; iwr_sop = s; iwr_eop = e; iwr_dat = d;
        while (!owr_rdy && t < 10) begin
            @(negedge iclk);
            t++;
        end
        if (t >= 10) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: got owr_rdy=0 expected 1 within 10 cycles");
        end
        @(negedge iclk);
        iwr_val = 1'b0; iwr_sop = 1'b0; iwr_eop = 1'b0;
    endtask

    task automatic send(input int base, input int n, input bit sop_en, input int eop_at);
        for (int i = 0; i < n; i++)
            beat(sop_en && (i == 0), (i == eop_at), DW'(base + i));
    endtask

    task automatic rd(input int a, input int exp, input string name);
        addr = AW'(a); ival = 1'b1;
        @(negedge iclk);
        ival = 1'b0;
        chk(name, odat, DW'(exp));
    endtask

    typedef struct {
        int base;
        int nwords;
        bit has_sop;
        int eop_at;
        int pre_words;
        bit cont_rd;
        int exp_err;
        int exp_done;
        bit exp_bank;
        int rd_addr;
        int exp_dat;
    } scen_t;

    scen_t tbl[7];

    initial begin
        int e0, d0, errs;
        tbl[0] = '{base:'h000, nwords:N,   has_sop:1, eop_at:N-1, pre_words:0,  cont_rd:0, exp_err:0, exp_done:1, exp_bank:1, rd_addr:2047, exp_dat:'h7ff};
        tbl[1] = '{base:'h100, nwords:N,   has_sop:1, eop_at:N-1, pre_words:0,  cont_rd:1, exp_err:0, exp_done:1, exp_bank:0, rd_addr:5,    exp_dat:'h105};
        tbl[2] = '{base:'h200, nwords:101, has_sop:1, eop_at:100, pre_words:0,  cont_rd:0, exp_err:1, exp_done:0, exp_bank:0, rd_addr:50,   exp_dat:'h132};
        tbl[3] = '{base:'h300, nwords:N,   has_sop:1, eop_at:-1,  pre_words:0,  cont_rd:0, exp_err:1, exp_done:0, exp_bank:0, rd_addr:5,    exp_dat:'h105};
        tbl[4] = '{base:'h900, nwords:3,   has_sop:0, eop_at:2,   pre_words:0,  cont_rd:0, exp_err:0, exp_done:0, exp_bank:0, rd_addr:2,    exp_dat:'h102};
        tbl[5] = '{base:'h400, nwords:N,   has_sop:1, eop_at:N-1, pre_words:0,  cont_rd:0, exp_err:0, exp_done:1, exp_bank:1, rd_addr:7,    exp_dat:'h407};
        tbl[6] = '{base:'h600, nwords:N,   has_sop:1, eop_at:N-1, pre_words:50, cont_rd:0, exp_err:1, exp_done:1, exp_bank:0, rd_addr:9,    exp_dat:'h609};

        // Reset values while reset is held.
        repeat (2) @(negedge iclk);
        chk("rst_rdy",  {71'd0, owr_rdy},    72'd1);
        chk("rst_done", {71'd0, oload_done}, 72'd0);
        chk("rst_err",  {71'd0, oload_err},  72'd0);
        chk("rst_bank", {71'd0, obank},      72'd0);
        chk("rst_vld",  {71'd0, otbl_vld},   72'd0);
        chk("rst_odat", odat,                72'd0);
        chk("rst_oval", {71'd0, oval},       72'd0);
        irst_n = 1'b1;
        @(negedge iclk);

        for (int k = 0; k < 7; k++) begin
            e0 = err_cnt; d0 = done_cnt; rdy_low = 0;
            if (tbl[k].cont_rd) begin
                addr = AW'(5); ival = 1'b1; cap_arm = 1;
            end
            if (tbl[k].pre_words > 0)
                send('h500, tbl[k].pre_words, 1'b1, -1);
            send(tbl[k].base, tbl[k].nwords, tbl[k].has_sop, tbl[k].eop_at);
            repeat (3) @(negedge iclk);
            ival = 1'b0;
            chk($sformatf("s%0d_err", k),  DW'(err_cnt - e0),  DW'(tbl[k].exp_err));
            chk($sformatf("s%0d_done", k), DW'(done_cnt - d0), DW'(tbl[k].exp_done));
            chk($sformatf("s%0d_rdylow", k), DW'(rdy_low),     DW'(tbl[k].exp_done));
            chk($sformatf("s%0d_bank", k), {71'd0, obank},     {71'd0, tbl[k].exp_bank});
            chk($sformatf("s%0d_vld", k),  {71'd0, otbl_vld},  72'd1);
            rd(tbl[k].rd_addr, tbl[k].exp_dat, $sformatf("s%0d_rd", k));
            if (tbl[k].cont_rd) begin
                chk("swap_old_data", dat_done,  72'h5);
                chk("swap_new_data", dat_after, 72'h105);
                cap_arm = 0;
            end
            if (k == 0) begin
                // Full sweep of the first table, plus read-valid timing.
                errs = 0;
                for (int a = 0; a < N; a++) begin
                    addr = AW'(a); ival = 1'b1;
                    @(negedge iclk);
                    if (odat !== DW'(a) || oval !== 1'b1) errs++;
                end
                ival = 1'b0;
                @(negedge iclk);
                chk("sweep_errors", DW'(errs), 72'd0);
                chk("oval_drop", {71'd0, oval}, 72'd0);
                chk("odat_hold", odat, 72'h7ff);
            end
        end

        // Asynchronous reset in the middle of a load.
        send('h700, 1000, 1'b1, -1);
        irst_n = 1'b0;
        #1;
        chk("mid_rdy",  {71'd0, owr_rdy},    72'd1);
        chk("mid_done", {71'd0, oload_done}, 72'd0);
        chk("mid_err",  {71'd0, oload_err},  72'd0);
        chk("mid_bank", {71'd0, obank},      72'd0);
        chk("mid_vld",  {71'd0, otbl_vld},   72'd0);
        chk("mid_odat", odat,                72'd0);
        chk("mid_oval", {71'd0, oval},       72'd0);
        @(negedge iclk);
        irst_n = 1'b1;
        @(negedge iclk);
        d0 = done_cnt;
        send('h800, N, 1'b1, N - 1);
        repeat (3) @(negedge iclk);
        chk("post_done", DW'(done_cnt - d0), 72'd1);
        chk("post_bank", {71'd0, obank},     72'd1);
        chk("post_vld",  {71'd0, otbl_vld},  72'd1);
        rd(3, 'h803, "post_rd");
        rd(2047, 'h800 + 2047, "post_rd_last");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pss_ram_writer.md
# pss_ram_writer

Run-time loader for the PSS reference table used by the sync correlator. It accepts a framed stream of pDAT_W-bit reference words and writes them into a ping-pong (two-bank) table. A complete sequence can therefore be replaced, for example on an N_ID_2 change, while the correlator keeps reading the other bank. On a valid load the read bank swaps atomically. The read side keeps the addr/ival/odat interface and one-cycle registered latency of the static PSS table, so the correlator needs no change.

## Interface
Parameters:
- pDAT_W, 72, width of one reference word
- pDAT_Num, 2048, words per sequence (≥ 2); one bank holds pDAT_Num words
- pADDR_W, 11, address width; pDAT_Num ≤ 2**pADDR_W

Ports:
- iclk  in  1  single clock; all logic on its rising edge
- irst_n  in  1  asynchronous, active-low reset
- iwr_sop  in  1  first word of a load sequence
- iwr_eop  in  1  last word of a load sequence
- iwr_val  in  1  write beat valid
- iwr_dat  in  pDAT_W  write word
- owr_rdy  out  1  writer ready; a beat is accepted when iwr_val & owr_rdy
- oload_done  out  1  one-cycle pulse: bank swapped, new sequence live
- oload_err  out  1  one-cycle pulse: framing error, load discarded
- obank  out  1  index of the bank currently served to the read port
- otbl_vld  out  1  at least one successful load since reset
- addr  in  pADDR_W  read address
- ival  in  1  read enable
- odat  out  pDAT_W  read data, registered
- oval  out  1  ival delayed one cycle

## Operation
- Storage: 2·pDAT_Num × pDAT_W simple dual-port RAM, inferred and not reset. Write address is {~obank, wcnt}; read address is {obank, addr}. Writes always target the inactive bank, so there is no read/write collision.
- FSM states are IDLE, LOAD and SWAP. wcnt is a pADDR_W-bit counter.
- IDLE, owr_rdy=1:
  - Accepted beat with iwr_sop: write the word at wcnt=0, set wcnt=1, go to LOAD.
  - Accepted beat without iwr_sop: ignored, no error.
- LOAD, owr_rdy=1, on each accepted beat:
  - iwr_sop=1: restart. Write the word at 0, set wcnt=1, pulse oload_err, stay in LOAD.
  - iwr_eop=1 and wcnt==pDAT_Num-1: write the word, go to SWAP.
  - iwr_eop=1 and wcnt≠pDAT_Num-1 (short frame): write the word, pulse oload_err, go to IDLE.
  - iwr_eop=0 and wcnt==pDAT_Num-1 (long frame): write the word, pulse oload_err, go to IDLE.
  - Otherwise: write the word, wcnt+1.
  - sop and eop on the same beat in LOAD are handled as a restart, i.e. the sop rule wins.
- SWAP, owr_rdy=0, one cycle: toggle obank, pulse oload_done, set otbl_vld=1, go to IDLE.
- Errors never swap the bank. The inactive bank is left partially overwritten, which is harmless because it is not being read.
- Read side: when ival=1, odat ← RAM[{obank,addr}] and oval ← 1. When ival=0, odat holds its value and oval ← 0.
- Before otbl_vld=1, reads are legal but odat content is undefined.
- Reset, asynchronous, any state including mid-LOAD: state=IDLE, wcnt=0, owr_rdy=1, oload_done=0, oload_err=0, obank=0, otbl_vld=0, odat=0, oval=0. RAM contents are kept, but otbl_vld=0 marks them invalid.

## Timing
- Write acceptance: a beat is taken at edge E when iwr_val & owr_rdy are both high. Beats offered while owr_rdy=0 are not taken; upstream must hold them.
- Valid eop accepted at edge E:
  - E to E+1: state SWAP, owr_rdy=0.
  - From E+1: obank toggled, oload_done=1 for exactly one cycle, owr_rdy=1.
- Bank switch seen by reads:
  - A read sampled at edge E+1 still uses the old bank.
  - Reads sampled at E+2 and later use the new bank.
  - No read ever returns a mix of the two banks.
- Error detected on the beat at edge E: oload_err=1 during the cycle after E, for exactly one cycle.
- Read latency: addr and ival sampled at edge R; odat and oval are valid after R, i.e. one cycle.
- Back-to-back loads:
  - Throughput is pDAT_Num+1 cycles per load (one SWAP bubble).
  - A sop may be accepted at E+1, the first edge after the SWAP cycle.

## Test plan
- Reset, then load pDAT_Num words D[i]=i with continuous valid and sop/eop framing; read addr 0..2047 -> odat=i one cycle after each ival; oload_done pulses once; obank=1; otbl_vld=1.
- During continuous reads of addr 5, load a second sequence D[i]=i+0x100 -> odat=5 through the read sampled at E+1 and 0x105 from E+2 onward; owr_rdy=0 for exactly one cycle.
- Short frame, eop at word 100 -> oload_err single pulse, no oload_done, obank unchanged, reads still return the old table.
- Long frame, no eop at word 2047 -> oload_err pulse; a subsequent correct load succeeds and swaps.
- sop re-asserted at word 50 of a load, then a full correct 2048-word frame -> one oload_err pulse, then oload_done; table equals the second frame.
- Assert irst_n=0 mid-LOAD at word 1000 -> all outputs at reset values immediately; a following full load completes with obank=1.
